layer_scheduler: RTL and testbench

Sequencing controller that time-multiplexes one shared IEEE754 multiply-accumulate datapath across all neurons of a fully-connected layer. For each neuron it steps the input mux and weight memory, clears, accumulates and biases the MAC, applies ReLU and emits one activation with its neuron index. It sits between the layer-level control (start/done) and the MAC, input multiplexer and weight/bias memories, replacing per-neuron private sequencing.

---
 rtl/neuron_pkg.sv | 22 ++
 rtl/relu.sv | 14 +
 rtl/layer_scheduler.sv | 136 +++++++++++++
 tb/tb_layer_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron-layer datapath blocks.
// Contents: sequencer state encoding, IEEE754 single-precision word type,
// and a width helper that never returns less than one bit.
package neuron_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ACC   = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef logic [31:0] float32_t;

    // Bits needed to index n items, minimum 1 so single-item counters stay legal.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/relu.sv
// ReLU on an IEEE754 single-precision word.
// Ports:
//   a_i : input word
//   y_o : a_i when the sign bit is clear, +0.0 otherwise (so -0.0 maps to +0.0)
module relu
    import neuron_pkg::*;
(
    input  float32_t a_i,
    output float32_t y_o
);

    assign y_o = a_i[31] ? '0 : a_i;

endmodule

// File: rtl/layer_scheduler.sv
// Sequencer that shares one MAC datapath across all neurons of a
// fully-connected layer: per neuron it clears the accumulator, streams
// NUM_INPUTS weight*input products, adds the bias and emits ReLU(result).
// Ports:
//   clock, reset (sync, active-low)
//   start        : begin a layer (honoured only in IDLE)
//   hold         : stall; freezes state/counters, suppresses all strobes
//   mac_result   : registered accumulator from the MAC
//   busy, done   : layer status; done is a one-cycle pulse
//   in_sel       : input-mux select
//   weight_addr  : weight memory address (1-cycle read latency)
//   bias_addr    : bias memory address (1-cycle read latency)
//   mac_clear, mac_acc_en, mac_bias_en : MAC control strobes
//   out_valid, out_index, out_data     : activation output
module layer_scheduler
    import neuron_pkg::*;
#(
    parameter  int NUM_INPUTS  = 4,
    parameter  int NUM_NEURONS = 4,
    localparam int IW = width_of(NUM_INPUTS),
    localparam int NW = width_of(NUM_NEURONS),
    localparam int AW = width_of(NUM_INPUTS * NUM_NEURONS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          hold,
    input  float32_t      mac_result,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] in_sel,
    output logic [AW-1:0] weight_addr,
    output logic [NW-1:0] bias_addr,
    output logic          mac_clear,
    output logic          mac_acc_en,
    output logic          mac_bias_en,
    output logic          out_valid,
    output logic [NW-1:0] out_index,
    output float32_t      out_data
);

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [IW-1:0] k_q, k_d;
    float32_t      relu_y;

    logic k_last;
    logic n_last;

    assign k_last = (k_q == IW'(NUM_INPUTS - 1));
    assign n_last = (n_q == NW'(NUM_NEURONS - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        if (!hold) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        n_d     = '0;
                        k_d     = '0;
                    end
                end
                S_LOAD: state_d = S_ACC;
                S_ACC: begin
                    if (k_last) begin
                        state_d = S_BIAS;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
                S_BIAS: state_d = S_WRITE;
                S_WRITE: begin
                    if (n_last) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = S_LOAD;
                    end
                end
                S_DONE: begin
                    // Return n to 0 so IDLE presents all-zero addresses.
                    state_d = S_IDLE;
                    n_d     = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; hold only masks the strobes, the
    // address outputs stay put because the counters they derive from are frozen.
    always_comb begin
        busy        = (state_q != S_IDLE);
        mac_clear   = !hold && (state_q == S_LOAD);
        mac_acc_en  = !hold && (state_q == S_ACC);
        mac_bias_en = !hold && (state_q == S_BIAS);
        out_valid   = !hold && (state_q == S_WRITE);
        done        = !hold && (state_q == S_DONE);
        in_sel      = k_q;
        bias_addr   = n_q;
        out_index   = n_q;
        weight_addr = '0;
        if (state_q == S_LOAD) begin
            weight_addr = AW'(n_q) * AW'(NUM_INPUTS);
        end else if (state_q == S_ACC) begin
            // Prefetch the next weight; on the last ACC cycle the value is unused
            // and may wrap harmlessly.
            weight_addr = AW'(n_q) * AW'(NUM_INPUTS) + AW'(k_q) + AW'(1);
        end
    end

    relu u_relu (
        .a_i (mac_result),
        .y_o (relu_y)
    );

    // Gate with out_valid so the output word reads zero outside a write.
    assign out_data = out_valid ? relu_y : '0;

endmodule

// File: tb/tb_layer_scheduler.sv
module tb_layer_scheduler;
    import neuron_pkg::*;

    localparam int NI = 4;
    localparam int NN = 2;
    localparam int IW = width_of(NI);
    localparam int NW = width_of(NN);
    localparam int AW = width_of(NI * NN);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1 (4 inputs, 2 neurons)
    logic          rst_n, start, hold;
    float32_t      mac_result;
    logic          busy, done, mac_clear, mac_acc_en, mac_bias_en, out_valid;
    logic [IW-1:0] in_sel;
    logic [AW-1:0] weight_addr;
    logic [NW-1:0] bias_addr, out_index;
    float32_t      out_data;

    layer_scheduler #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
        .clock(clk), .reset(rst_n), .start(start), .hold(hold),
        .mac_result(mac_result), .busy(busy), .done(done), .in_sel(in_sel),
        .weight_addr(weight_addr), .bias_addr(bias_addr), .mac_clear(mac_clear),
        .mac_acc_en(mac_acc_en), .mac_bias_en(mac_bias_en), .out_valid(out_valid),
        .out_index(out_index), .out_data(out_data)
    );

    // DUT 2 (1 input, 1 neuron)
    logic     start2, hold2;
    float32_t mr2;
    logic     busy2, done2, clr2, acc2, bias2, valid2;
    logic     in_sel2, waddr2, baddr2, idx2;
    float32_t data2;

    layer_scheduler #(.NUM_INPUTS(1), .NUM_NEURONS(1)) dut2 (
        .clock(clk), .reset(rst_n), .start(start2), .hold(hold2),
        .mac_result(mr2), .busy(busy2), .done(done2), .in_sel(in_sel2),
        .weight_addr(waddr2), .bias_addr(baddr2), .mac_clear(clr2),
        .mac_acc_en(acc2), .mac_bias_en(bias2), .out_valid(valid2),
        .out_index(idx2), .out_data(data2)
    );

    // Integer-valued float helpers for the MAC model
    function automatic int f2i(input logic [31:0] f);
        int e, v;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        v = int'({8'd0, 1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] int2f(input int v);
        int a, p;
        logic [31:0] mant;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (a[i]) p = i;
        mant = 32'(a) << (23 - p);
        return {(v < 0), 8'(127 + p), mant[22:0]};
    endfunction

    // MAC and memory model
    logic [31:0] wmem [NI*NN];
    logic [31:0] inmem [NI];
    logic [31:0] bmem [NN];
    logic [31:0] wdata_q, bdata_q;
    int          acc;

    always @(posedge clk) begin
        wdata_q <= wmem[weight_addr];
        bdata_q <= bmem[bias_addr];
        if (mac_clear) acc <= 0;
        else if (mac_acc_en) acc <= acc + f2i(wdata_q) * f2i(inmem[in_sel]);
        else if (mac_bias_en) acc <= acc + f2i(bdata_q);
    end
    assign mac_result = int2f(acc);

    // Vector table
    typedef struct {
        int          in_v [NI];
        int          w_v  [NI*NN];
        int          b_v  [NN];
        logic [31:0] exp_d [NN];
    } vec_t;
    vec_t tbl [5];

    typedef struct packed {
        logic [NW-1:0] idx;
        logic [31:0]   data;
    } sb_t;
    sb_t sbq [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic sample_sb();
        sb_t e;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected at %0t: out_valid with index %0d data %h, expected none",
                         $time, out_index, out_data);
            end else begin
                e = sbq.pop_front();
                chk("sb_index", 32'(out_index), 32'(e.idx));
                chk("sb_data", out_data, e.data);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_in_sel"}, 32'(in_sel), 32'd0);
        chk({tag, "_waddr"}, 32'(weight_addr), 32'd0);
        chk({tag, "_baddr"}, 32'(bias_addr), 32'd0);
        chk({tag, "_strobes"}, 32'({mac_clear, mac_acc_en, mac_bias_en, out_valid}), 32'd0);
        chk({tag, "_out_index"}, 32'(out_index), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
    endtask

    task automatic load_entry(input int i, input int push_n);
        sb_t e;
        for (int a = 0; a < NI*NN; a++) wmem[a] = int2f(tbl[i].w_v[a]);
        for (int a = 0; a < NI; a++) inmem[a] = int2f(tbl[i].in_v[a]);
        for (int a = 0; a < NN; a++) bmem[a] = int2f(tbl[i].b_v[a]);
        for (int n = 0; n < push_n; n++) begin
            e.idx  = NW'(n);
            e.data = tbl[i].exp_d[n];
            sbq.push_back(e);
        end
    endtask

    // Cycle c counts from the edge that accepts start (cycle 1 = first LOAD).
    // Arguments of 0 / -5 mean "no such event".
    task automatic run_layer(input int v0, input int v1, input int busy_until,
                             input int done_c, input int end_c, input int hold_from,
                             input int hold_len, input int restart_c, input int reset_c,
                             input bit chk_waddr);
        start = 1'b1;
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk);
            #1;
            start = (c == restart_c);
            hold  = (c >= hold_from) && (c < hold_from + hold_len);
            rst_n = !(c == reset_c);
            @(negedge clk);
            sample_sb();
            chk("busy", 32'(busy), 32'(c <= busy_until));
            chk("done", 32'(done), 32'(c == done_c));
            chk("out_valid", 32'(out_valid), 32'((c == v0) || (c == v1)));
            if (hold) begin
                // Stall lands on neuron 0, second ACC cycle (k=1).
                chk("hold_strobes", 32'({mac_clear, mac_acc_en, mac_bias_en}), 32'd0);
                chk("hold_waddr", 32'(weight_addr), 32'd2);
                chk("hold_in_sel", 32'(in_sel), 32'd1);
            end
            if (chk_waddr && c >= 8 && c <= 11)
                chk("waddr_n1", 32'(weight_addr), 32'(c - 4));
            if (c == reset_c + 1) check_all_zero("midreset");
        end
        start = 1'b0;
        hold  = 1'b0;
        chk("sb_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic run2(input logic [31:0] mr, input logic [31:0] expd);
        mr2    = mr;
        start2 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            start2 = 1'b0;
            @(negedge clk);
            chk("d2_clear", 32'(clr2), 32'(c == 1));
            chk("d2_acc", 32'(acc2), 32'(c == 2));
            chk("d2_bias", 32'(bias2), 32'(c == 3));
            chk("d2_valid", 32'(valid2), 32'(c == 4));
            chk("d2_done", 32'(done2), 32'(c == 5));
            chk("d2_busy", 32'(busy2), 32'(c <= 5));
            if (c == 4) begin
                chk("d2_index", 32'(idx2), 32'd0);
                chk("d2_data", data2, expd);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].in_v = '{1, 1, 1, 1};  tbl[0].w_v = '{1, 1, 1, 1, 1, 1, 1, 1};
        tbl[0].b_v  = '{-1, -6};      tbl[0].exp_d = '{32'h40400000, 32'h00000000};
        tbl[1].in_v = '{1, 2, 3, 4};  tbl[1].w_v = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[1].b_v  = '{0, 0};        tbl[1].exp_d = '{32'h3F800000, 32'h40800000};
        tbl[2].in_v = '{1, 2, 3, 4};  tbl[2].w_v = '{1, 1, 1, 1, 2, 0, 0, 0};
        tbl[2].b_v  = '{-11, 5};      tbl[2].exp_d = '{32'h00000000, 32'h40E00000};
        tbl[3].in_v = '{2, 0, 1, 0};  tbl[3].w_v = '{0, 0, 3, 0, 0, 0, 0, 0};
        tbl[3].b_v  = '{1, 0};        tbl[3].exp_d = '{32'h40800000, 32'h00000000};
        tbl[4].in_v = '{1, 2, 3, 4};  tbl[4].w_v = '{0, 0, 0, 2, 0, 0, 1, 0};
        tbl[4].b_v  = '{0, -2};       tbl[4].exp_d = '{32'h41000000, 32'h3F800000};

        rst_n = 1'b0; start = 1'b0; hold = 1'b0;
        start2 = 1'b0; hold2 = 1'b0; mr2 = 32'h0;
        for (int a = 0; a < NI*NN; a++) wmem[a] = 32'h0;
        for (int a = 0; a < NI; a++) inmem[a] = 32'h0;
        for (int a = 0; a < NN; a++) bmem[a] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        chk("reset_d2", 32'({busy2, done2, valid2, clr2}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Full-timing run, then the rest of the table back-to-back
        load_entry(0, NN);
        run_layer(7, 14, 15, 15, 16, 0, 0, 0, -5, 1'b1);
        for (int i = 1; i < 5; i++) begin
            load_entry(i, NN);
            run_layer(7, 14, 15, 15, 16, 0, 0, 0, -5, 1'b0);
        end

        // Three-cycle stall in the second ACC cycle: same results, 3 cycles later
        load_entry(0, NN);
        run_layer(10, 17, 18, 18, 19, 3, 3, 0, -5, 1'b0);

        // Re-start while busy is ignored; reset in cycle 9 aborts with no done
        load_entry(0, 1);
        run_layer(7, 0, 9, 0, 14, 0, 0, 5, 9, 1'b0);

        // Clean run after the abort
        load_entry(2, NN);
        run_layer(7, 14, 15, 15, 16, 0, 0, 0, -5, 1'b0);

        // Single-input, single-neuron instance and ReLU corner cases
        run2(32'h40000000, 32'h40000000);
        run2(32'h80000000, 32'h00000000);
        run2(32'hC0000000, 32'h00000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
